// File: rtl/alu_pkg.sv
// Shared encodings for the registered ALU with sequential multiply.
package alu_pkg;

  // Operation select encodings (same as the original combinational ALU).
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  // Control states: idle, multiply in progress, result held for the consumer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_core_comb.sv
// Single-cycle ALU operations (everything except MUL) producing y, carry/borrow
// and signed overflow. Purely combinational; the top registers the results.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   sel,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf
);

  logic [N:0]   sum;
  logic [N-1:0] diff;

  // Decode sel; unknown or MUL encodings fall back to AND.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = a + ~b + N'(1);
    y    = a & b;
    cout = 1'b0;
    ovf  = 1'b0;
    case (sel)
      OP_OR:   y = a | b;
      OP_ADD: begin
        y    = sum[N-1:0];
        cout = sum[N];
        ovf  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y    = diff;
        cout = (a < b);
        ovf  = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/alu_seq_mul_with_zero.sv
// Registered ALU with zero flag and an N-cycle shift-add multiplier.
// Handshake: an operation is accepted on a rising edge where in_valid && in_ready;
// a result is taken on a rising edge where out_valid && out_ready. y and flags
// hold stable while out_valid is high and out_ready is low.
module alu_seq_mul_with_zero
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic         Z_flag,
  output alu_state_e   dbg_state
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  alu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   y_q, y_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           z_q, z_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]   core_y;
  logic           core_cout;
  logic           core_ovf;
  logic [2*N-1:0] mul_sum;
  logic           accept;

  alu_core_comb #(.N(N)) u_core (
    .a    (a),
    .b    (b),
    .sel  (sel),
    .y    (core_y),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // A new op can enter when idle, or when the held result leaves this same edge.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Partial sum including the multiplier bit examined this cycle.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state, multiply datapath and result register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    y_d         = y_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: ;
      ST_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last multiplier bit: publish the product on this edge.
        if (cnt_q == CW'(N - 1)) begin
          y_d         = mul_sum[N-1:0];
          cout_d      = |mul_sum[2*N-1:N];
          ovf_d       = 1'b0;
          z_d         = (mul_sum[N-1:0] == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An accept (from IDLE or from DONE while draining) overrides the above.
    if (accept) begin
      if (sel == OP_MUL) begin
        mcand_d     = {{N{1'b0}}, a};
        mplier_d    = b;
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        state_d     = ST_MUL;
      end else begin
        y_d         = core_y;
        cout_d      = core_cout;
        ovf_d       = core_ovf;
        z_d         = (core_y == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      z_q         <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign Z_flag    = z_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_mul_with_zero.sv
// Self-checking bench for alu_seq_mul_with_zero: directed vectors with literal
// expectations plus a negedge checker comparing against an arithmetic model.
module tb_alu_seq_mul_with_zero;
  import alu_pkg::*;

  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [2:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  y;
  logic          cout;
  logic          ovf;
  logic          Z_flag;
  alu_state_e    dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Scoreboard: packed {y, cout, ovf, z} plus the cycle the result must appear.
  logic [N+2:0] exp_q[$];
  int           due_q[$];
  logic         seen = 1'b0;

  alu_seq_mul_with_zero #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf),
    .Z_flag    (Z_flag),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [N+2:0] model(input logic [2:0] s, input logic [N-1:0] x,
                                         input logic [N-1:0] v);
    logic [63:0]  full;
    logic [N-1:0] r;
    logic         c;
    logic         o;
    longint       sx;
    longint       sv;
    longint       sr;
    full = '0;
    c    = 1'b0;
    o    = 1'b0;
    sx   = longint'($signed(x));
    sv   = longint'($signed(v));
    sr   = 0;
    case (s)
      OP_AND:  r = x & v;
      OP_OR:   r = x | v;
      OP_ADD: begin
        full = {32'b0, x} + {32'b0, v};
        r    = full[N-1:0];
        c    = full[N];
        sr   = sx + sv;
        o    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        r  = x - v;
        c  = (x < v);
        sr = sx - sv;
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_ANDN: r = x & ~v;
      OP_ORN:  r = x | ~v;
      OP_MUL: begin
        full = {32'b0, x} * {32'b0, v};
        r    = full[N-1:0];
        c    = (full[63:32] != 32'b0);
      end
      default: r = (sx < sv) ? 32'd1 : 32'd0;
    endcase
    return {r, c, o, (r == '0)};
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic will_xfer;
    logic will_acc;
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      seen = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("idle_out_valid", {63'b0, out_valid}, 64'd0);
        chk("idle_in_ready", {63'b0, in_ready}, 64'd1);
      end else if (!seen) begin
        if (cyc < due_q[0]) begin
          chk("busy_out_valid", {63'b0, out_valid}, 64'd0);
          chk("busy_in_ready", {63'b0, in_ready}, 64'd0);
        end else begin
          chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
          seen = 1'b1;
        end
      end
      if (seen && exp_q.size() != 0) begin
        chk("sb_result", {29'b0, y, cout, ovf, Z_flag}, {29'b0, exp_q[0]});
        chk("sb_done_in_ready", {63'b0, in_ready}, {63'b0, out_ready});
      end
      will_xfer = out_valid && out_ready;
      will_acc  = in_valid && in_ready;
      if (will_xfer && seen && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        seen = 1'b0;
      end
      if (will_acc) begin
        exp_q.push_back(model(sel, a, b));
        due_q.push_back(cyc + 1 + ((sel == OP_MUL) ? N : 0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present an op and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic [2:0] s, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic ordy);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    @(posedge clk);
    #2;
    in_valid  = 1'b1;
    sel       = s;
    a         = av;
    b         = bv;
    out_ready = ordy;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Wait for out_valid; reports edges elapsed since the accept edge and the
  // in_ready seen in the first cycle after accept.
  task automatic wait_result(output logic got, output int edges, output logic first_rdy);
    got       = 1'b0;
    edges     = 0;
    first_rdy = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (k == 1) first_rdy = in_ready;
      if (out_valid) begin
        got   = 1'b1;
        edges = k - 1;
      end
    end
    if (!got) chk("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] s, input logic [N-1:0] av,
                        input logic [N-1:0] bv, input logic [N+2:0] ex, input int ex_edges);
    logic got;
    int   edges;
    logic first_rdy;
    issue(s, av, bv, 1'b1);
    wait_result(got, edges, first_rdy);
    if (got) begin
      chk({nm, "_result"}, {29'b0, y, cout, ovf, Z_flag}, {29'b0, ex});
      chk({nm, "_latency"}, 64'(edges), 64'(ex_edges));
      if (s == OP_MUL) chk({nm, "_busy_in_ready"}, {63'b0, first_rdy}, 64'd0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic got;
    int   edges;
    logic first_rdy;
    int   spurious;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = OP_AND;

    // Model pins against hand-computed values.
    chk("pin_add", {29'b0, model(OP_ADD, 32'h19, 32'h20)}, {29'b0, 32'h39, 3'b000});
    chk("pin_sub", {29'b0, model(OP_SUB, 32'h80000000, 32'h1)}, {29'b0, 32'h7FFFFFFF, 3'b010});
    chk("pin_mul", {29'b0, model(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF)},
        {29'b0, 32'h1, 3'b100});
    chk("pin_slt", {29'b0, model(OP_SLT, 32'hFFFFFFFF, 32'h1)}, {29'b0, 32'h1, 3'b000});

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_flags", {61'b0, cout, ovf, Z_flag}, 64'b001);
    #1;
    rst_n = 1'b1;

    // Basic ops on a=0x19, b=0x20.  Packed expectation is {y, cout, ovf, z}.
    run_op("add",  OP_ADD,  32'h19, 32'h20, {32'h39, 3'b000}, 0);
    run_op("sub",  OP_SUB,  32'h19, 32'h20, {32'hFFFFFFF9, 3'b100}, 0);
    run_op("slt",  OP_SLT,  32'h19, 32'h20, {32'h1, 3'b000}, 0);
    run_op("and",  OP_AND,  32'h19, 32'h20, {32'h0, 3'b001}, 0);
    run_op("andn", OP_ANDN, 32'h19, 32'h20, {32'h19, 3'b000}, 0);

    // Arithmetic boundaries.
    run_op("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h1, {32'h80000000, 3'b010}, 0);
    run_op("add_carry", OP_ADD, 32'hFFFFFFFF, 32'h1, {32'h0, 3'b101}, 0);
    run_op("sub_ovf",   OP_SUB, 32'h80000000, 32'h1, {32'h7FFFFFFF, 3'b010}, 0);

    // Multiply: latency N, busy while iterating.
    run_op("mul_small", OP_MUL, 32'h19, 32'h20, {32'h320, 3'b000}, N);
    run_op("mul_hi",    OP_MUL, 32'h10000, 32'h10000, {32'h0, 3'b101}, N);
    run_op("mul_max",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h1, 3'b100}, N);

    // Backpressure then back-to-back accept on the draining edge.
    issue(OP_ORN, 32'h19, 32'h20, 1'b0);
    wait_result(got, edges, first_rdy);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      chk("bp_hold_y", 64'(y), 64'hFFFFFFDF);
      chk("bp_hold_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = OP_OR;
    a         = 32'h19;
    b         = 32'h20;
    @(negedge clk);
    chk("b2b_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", {63'b0, out_valid}, 64'd1);
    chk("b2b_y", 64'(y), 64'h39);

    // Leave a nonzero result in y, then reset in the middle of a multiply.
    run_op("add_pre", OP_ADD, 32'h5, 32'h6, {32'hB, 3'b000}, 0);
    issue(OP_MUL, 32'h5, 32'h7, 1'b1);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_y", 64'(y), 64'd0);
    chk("async_rst_z", {63'b0, Z_flag}, 64'd1);
    chk("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("aborted_mul_no_valid", 64'(spurious), 64'd0);
    run_op("add_after_rst", OP_ADD, 32'h19, 32'h20, {32'h39, 3'b000}, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq_mul_with_zero.md
Name: alu_seq_mul_with_zero

Overview:
Parametrised, registered successor to the combinational 32-bit ALU with zero flag.
- Accepts one operation per valid/ready handshake and returns registered results plus flags (carry/borrow, signed overflow, zero) through a second handshake.
- Adds an iterative shift-add multiply op that takes N cycles.
- Sits between the operand/issue logic and the writeback stage of the datapath.

Parameters:
N, 32, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operands and sel presented
in_ready  output  1  block can accept an operation this cycle
a  input  N  operand A
b  input  N  operand B
sel  input  3  operation select
out_valid  output  1  y and flags hold a completed result
out_ready  input  1  consumer takes the result this cycle
y  output  N  registered result
cout  output  1  carry (ADD), borrow (SUB), nonzero upper half (MUL); 0 otherwise
ovf  output  1  signed overflow (ADD/SUB only); 0 otherwise
Z_flag  output  1  1 when y == 0

Behaviour:
- Reset: clk/rst_n are the only clock and reset. Reset is asynchronous, active-low.
  - Reset values: state IDLE, out_valid=0, y=0, cout=0, ovf=0, Z_flag=1, multiply counter 0.
- sel encoding (unchanged from the combinational ALU):
  - 000 AND; 001 OR; 010 ADD; 011 SUB; 100 A&~B; 101 A|~B; 110 MUL; 111 SLT (signed).
- Arithmetic:
  - ADD: {cout,y} = a+b. ovf = (a[N-1]==b[N-1]) && (y[N-1]!=a[N-1]).
  - SUB: y = a+~b+1. cout = 1 when a < b unsigned (borrow). ovf = (a[N-1]!=b[N-1]) && (y[N-1]!=a[N-1]).
  - SLT: y = {N-1 zeros, signed(a)<signed(b)}; cout=0, ovf=0.
  - Logic ops: cout=0, ovf=0.
  - MUL: unsigned; y = low N bits of a*b; cout = |(high N bits); ovf=0.
  - Z_flag = (y==0), registered together with y.
- Handshake:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result transfer occurs when out_valid && out_ready at an edge.
- State machine (IDLE, MUL, DONE):
  - IDLE, accept non-MUL: result and flags registered on the accept edge -> DONE. out_valid is high the cycle after accept (latency 1).
  - IDLE, accept MUL: latch a, b; clear accumulator; counter=0 -> MUL.
  - MUL: one bit of b per cycle, LSB first; counter increments. On the edge where counter reaches N-1, the result is written -> DONE. out_valid rises exactly N cycles after the accept edge.
  - DONE: y and flags held stable while out_ready=0.
    - out_ready=1 and no new accept -> IDLE, out_valid=0.
    - out_ready=1 with a simultaneous accept -> behaves as an accept from IDLE: back-to-back, no bubble for non-MUL ops.
- Boundary conditions:
  - in_valid while busy (MUL, or DONE with out_ready=0): not accepted. The source holds its inputs.
  - Reset mid-MUL: aborts the operation, no result, out_valid stays 0.
  - sel with X/Z is treated as AND in synthesis. The bench does not drive it.
  - Outputs change only on accepted/completing edges. They are never combinational from a, b or sel.

Decomposition:
- Package alu_pkg:
  - sel encodings: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_ANDN, OP_ORN, OP_MUL, OP_SLT.
  - State encodings: ST_IDLE, ST_MUL, ST_DONE.
- Sub-module alu_core_comb: combinational single-cycle ops producing {y, cout, ovf} for every sel except MUL.
- The top level holds the FSM, multiply accumulator/counter, and output registers.

Test Plan:
- Reset: hold rst_n low, release -> out_valid=0, in_ready=1, y=0, Z_flag=1. Assert rst_n mid-cycle -> outputs clear immediately, without waiting for clk.
- ADD a=0x19, b=0x20 -> one cycle after accept: y=0x39, cout=0, ovf=0, Z_flag=0. SUB same operands -> y=0xFFFFFFF9, cout=1. SLT same operands -> y=1. AND same operands -> y=0, Z_flag=1.
- ADD 0x7FFFFFFF+0x1 -> y=0x80000000, ovf=1, cout=0. ADD 0xFFFFFFFF+0x1 -> y=0, cout=1, Z_flag=1. SUB 0x80000000-0x1 -> y=0x7FFFFFFF, ovf=1.
- MUL 0x19*0x20 -> in_ready=0 during MUL; out_valid rises exactly 32 cycles after accept; y=0x320, cout=0. MUL 0x10000*0x10000 -> y=0, cout=1, Z_flag=1.
- Backpressure: after ORN a=0x19, b=0x20, hold out_ready=0 for 5 cycles -> y=0xFFFFFFDF stable, in_ready=0. Then assert out_ready=1 with in_valid=1, OR 0x19|0x20 -> both handshakes on the same edge; next cycle y=0x39, out_valid=1.
- Reset at cycle 10 of MUL -> out_valid never rises for that operation; after release in_ready=1 and a fresh ADD completes correctly.
